// File: rtl/battleship_board_store_if.sv
// Command/response channel between the game/input logic and the board store.
// The master issues commands; the slave (board store) returns one result per command.
interface battleship_board_store_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_row;
  logic [3:0] cmd_col;
  logic       rsp_valid;
  logic [1:0] rsp_code;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col,
    input  cmd_ready, rsp_valid, rsp_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col,
    output cmd_ready, rsp_valid, rsp_code
  );
endinterface

// File: rtl/battleship_board_store.sv
// 10x10 Battleship board state with place/fire/clear commands, feeding the
// VGA row buses A..J, the turn flag and the remaining-ship-cell counter.
module battleship_board_store #(
  parameter int ROWS  = 10,
  parameter int COLS  = 10,
  parameter int CNT_W = 7
) (
  input  logic                 clock50,
  input  logic                 reset,
  battleship_board_store_if.slave cmd,
  output logic [19:0]          A,
  output logic [19:0]          B,
  output logic [19:0]          C,
  output logic [19:0]          D,
  output logic [19:0]          E,
  output logic [19:0]          F,
  output logic [19:0]          G,
  output logic [19:0]          H,
  output logic [19:0]          I,
  output logic [19:0]          J,
  output logic                 playerTurn,
  output logic [CNT_W-1:0]     ship_cells,
  output logic                 game_over
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_PLACE = 2'b00;
  localparam logic [1:0] OP_FIRE  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [1:0] RSP_OK     = 2'b00;
  localparam logic [1:0] RSP_HIT    = 2'b01;
  localparam logic [1:0] RSP_REPEAT = 2'b10;
  localparam logic [1:0] RSP_ERROR  = 2'b11;

  logic [1:0]       state_r;
  logic [1:0]       lat_op_r;
  logic [3:0]       lat_row_r;
  logic [3:0]       lat_col_r;
  logic [3:0]       clr_idx_r;
  logic [19:0]      board_r [0:9];
  logic             turn_r;
  logic [CNT_W-1:0] cells_r;
  logic             over_r;
  logic             rsp_valid_r;
  logic [1:0]       rsp_code_r;

  logic             in_range_s;
  logic [3:0]       row_idx_s;
  logic [4:0]       shamt_s;
  logic [19:0]      sel_row_s;
  logic [1:0]       cell_s;
  logic             wr_s;
  logic [1:0]       new_cell_s;
  logic [19:0]      new_row_s;
  logic [1:0]       code_s;
  logic             inc_s;
  logic             dec_s;
  logic             tog_s;

  assign cmd.cmd_ready = (state_r == IDLE);
  assign cmd.rsp_valid = rsp_valid_r;
  assign cmd.rsp_code  = rsp_code_r;

  assign A = board_r[0];
  assign B = board_r[1];
  assign C = board_r[2];
  assign D = board_r[3];
  assign E = board_r[4];
  assign F = board_r[5];
  assign G = board_r[6];
  assign H = board_r[7];
  assign I = board_r[8];
  assign J = board_r[9];

  assign playerTurn = turn_r;
  assign ship_cells = cells_r;
  assign game_over  = over_r;

  // Decode the latched command against the addressed cell: result code and board/counter effects.
  always_comb begin
    in_range_s = (lat_row_r < 4'(ROWS)) && (lat_col_r < 4'(COLS));
    // Out-of-range commands read row 0 so the array index never leaves the board.
    row_idx_s  = in_range_s ? lat_row_r : 4'd0;
    shamt_s    = 5'd18 - {lat_col_r, 1'b0};
    sel_row_s  = board_r[row_idx_s];
    cell_s     = 2'(sel_row_s >> shamt_s);
    wr_s       = 1'b0;
    new_cell_s = cell_s;
    code_s     = RSP_ERROR;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    tog_s      = 1'b0;
    case (lat_op_r)
      OP_PLACE: begin
        if (!in_range_s) begin
          code_s = RSP_ERROR;
        end else if (cell_s == CELL_WATER) begin
          wr_s       = 1'b1;
          new_cell_s = CELL_SHIP;
          inc_s      = 1'b1;
          code_s     = RSP_OK;
        end else begin
          code_s = RSP_REPEAT;
        end
      end
      OP_FIRE: begin
        if (!in_range_s || over_r) begin
          code_s = RSP_ERROR;
        end else begin
          case (cell_s)
            CELL_WATER: begin
              wr_s       = 1'b1;
              new_cell_s = CELL_MISS;
              tog_s      = 1'b1;
              code_s     = RSP_OK;
            end
            CELL_SHIP: begin
              wr_s       = 1'b1;
              new_cell_s = CELL_HIT;
              dec_s      = 1'b1;
              tog_s      = 1'b1;
              code_s     = RSP_HIT;
            end
            default: code_s = RSP_REPEAT;
          endcase
        end
      end
      OP_CLEAR: code_s = RSP_OK;
      default:  code_s = RSP_ERROR;
    endcase
    new_row_s = (sel_row_s & ~(20'h00003 << shamt_s)) | (20'(new_cell_s) << shamt_s);
  end

  // Command FSM, board storage, counter, turn and response registers.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      lat_op_r    <= 2'b00;
      lat_row_r   <= 4'd0;
      lat_col_r   <= 4'd0;
      clr_idx_r   <= 4'd0;
      turn_r      <= 1'b0;
      cells_r     <= '0;
      over_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_code_r  <= 2'b00;
      for (int r = 0; r < 10; r++) begin
        board_r[r] <= 20'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (cmd.cmd_valid) begin
            lat_op_r  <= cmd.cmd_op;
            lat_row_r <= cmd.cmd_row;
            lat_col_r <= cmd.cmd_col;
            state_r   <= EXEC;
          end
        end
        EXEC: begin
          if (lat_op_r == OP_CLEAR) begin
            clr_idx_r <= 4'd0;
            state_r   <= CLEAR;
          end else begin
            if (wr_s) begin
              board_r[row_idx_s] <= new_row_s;
            end
            if (inc_s) begin
              cells_r <= cells_r + CNT_W'(1);
              over_r  <= 1'b0;
            end
            // The decremented cell was the last ship cell: the game ends on this hit.
            if (dec_s) begin
              cells_r <= cells_r - CNT_W'(1);
              if (cells_r == CNT_W'(1)) begin
                over_r <= 1'b1;
              end
            end
            if (tog_s) begin
              turn_r <= ~turn_r;
            end
            rsp_valid_r <= 1'b1;
            rsp_code_r  <= code_s;
            state_r     <= RESP;
          end
        end
        CLEAR: begin
          board_r[clr_idx_r] <= 20'd0;
          clr_idx_r          <= clr_idx_r + 4'd1;
          if (clr_idx_r == 4'(ROWS - 1)) begin
            cells_r     <= '0;
            turn_r      <= 1'b0;
            over_r      <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_code_r  <= RSP_OK;
            state_r     <= RESP;
          end
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_board_store.sv
// Scoreboard bench: commands push expected result/latency, a monitor pops on every rsp_valid.
module tb_battleship_board_store;

  logic        clock50 = 1'b0;
  logic        reset   = 1'b1;
  logic [19:0] A, B, C, D, E, F, G, H, I, J;
  logic        playerTurn;
  logic [6:0]  ship_cells;
  logic        game_over;

  battleship_board_store_if bus();

  battleship_board_store dut (
    .clock50    (clock50),
    .reset      (reset),
    .cmd        (bus),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .E          (E),
    .F          (F),
    .G          (G),
    .H          (H),
    .I          (I),
    .J          (J),
    .playerTurn (playerTurn),
    .ship_cells (ship_cells),
    .game_over  (game_over)
  );

  always #10 clock50 = ~clock50;

  typedef struct {
    logic [1:0] code;
    int         lat;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          acc   = 0;
  logic [19:0] exp_rows [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] row_bus(input int r);
    case (r)
      0: return A;
      1: return B;
      2: return C;
      3: return D;
      4: return E;
      5: return F;
      6: return G;
      7: return H;
      8: return I;
      default: return J;
    endcase
  endfunction

  task automatic check_rows(input string tag);
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("%s_row%0d", tag, r), 32'(row_bus(r)), 32'(exp_rows[r]));
    end
  endtask

  // Acceptance edge number, used by the monitor to measure latency.
  always @(posedge clock50) begin
    cyc <= cyc + 1;
    if (!reset && bus.cmd_valid && bus.cmd_ready) acc <= cyc + 1;
  end

  // Monitor: pops the scoreboard on every response pulse.
  always @(negedge clock50) begin
    if (!reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got code %0d expected no response", bus.rsp_code);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_code", 32'(bus.rsp_code), 32'(mon_e.code));
        chk("rsp_latency", 32'(cyc - acc), 32'(mon_e.lat));
      end
    end
  end

  // Issue one command, optionally keep cmd_valid high while busy, and measure cmd_ready low time.
  task automatic send(input logic [1:0] op, input logic [3:0] r, input logic [3:0] c,
                      input logic [1:0] code, input int lat, input int rdy_low, input bit hold);
    int low;
    @(negedge clock50);
    bus.cmd_op    = op;
    bus.cmd_row   = r;
    bus.cmd_col   = c;
    bus.cmd_valid = 1'b1;
    exp_q.push_back('{code, lat});
    @(posedge clock50);
    #1;
    bus.cmd_valid = hold;
    if (hold) begin
      bus.cmd_op  = 2'b00;
      bus.cmd_row = 4'd2;
      bus.cmd_col = 4'd2;
    end
    low = 0;
    for (int k = 0; k < 60; k++) begin
      if (hold && bus.rsp_valid) bus.cmd_valid = 1'b0;
      if (bus.cmd_ready) break;
      low++;
      @(posedge clock50);
      #1;
    end
    bus.cmd_valid = 1'b0;
    chk("ready_low_cycles", 32'(low), 32'(rdy_low));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_row   = 4'd0;
    bus.cmd_col   = 4'd0;
    for (int r = 0; r < 10; r++) exp_rows[r] = 20'd0;
    repeat (3) @(posedge clock50);
    @(negedge clock50);
    reset = 1'b0;
    @(negedge clock50);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_code", 32'(bus.rsp_code), 32'd0);
    chk("rst_cells", 32'(ship_cells), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);

    // Reset in the middle of a clear aborts it without a response.
    send(2'b00, 4'd3, 4'd4, 2'b00, 1, 2, 1'b0);
    send(2'b00, 4'd7, 4'd7, 2'b00, 1, 2, 1'b0);
    exp_rows[3] = 20'h00400;
    exp_rows[7] = 20'h00010;
    check_rows("pre_clear");
    chk("two_cells", 32'(ship_cells), 32'd2);
    @(negedge clock50);
    bus.cmd_op    = 2'b10;
    bus.cmd_valid = 1'b1;
    @(posedge clock50);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clock50);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clock50);
    #1;
    reset = 1'b0;
    exp_rows[3] = 20'd0;
    exp_rows[7] = 20'd0;
    @(negedge clock50);
    check_rows("midclr_rst");
    chk("midclr_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midclr_turn", 32'(playerTurn), 32'd0);
    chk("midclr_cells", 32'(ship_cells), 32'd0);
    chk("midclr_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Place and repeat-place.
    send(2'b00, 4'd0, 4'd0, 2'b00, 1, 2, 1'b0);
    chk("place_A", 32'(A), 32'h40000);
    chk("place_cells", 32'(ship_cells), 32'd1);
    send(2'b00, 4'd0, 4'd0, 2'b10, 1, 2, 1'b0);
    chk("replace_cells", 32'(ship_cells), 32'd1);

    // Sink the only ship, then firing is rejected while game over.
    send(2'b01, 4'd0, 4'd0, 2'b01, 1, 2, 1'b0);
    chk("hit_A", 32'(A), 32'hC0000);
    chk("hit_cells", 32'(ship_cells), 32'd0);
    chk("hit_over", 32'(game_over), 32'd1);
    chk("hit_turn", 32'(playerTurn), 32'd1);
    chk("code_holds", 32'(bus.rsp_code), 32'd1);
    send(2'b01, 4'd5, 4'd5, 2'b11, 1, 2, 1'b0);
    chk("over_F", 32'(F), 32'd0);
    chk("over_turn", 32'(playerTurn), 32'd1);

    // Placing while game over reopens the game; then clear with cmd_valid held.
    send(2'b00, 4'd0, 4'd9, 2'b00, 1, 2, 1'b0);
    chk("reopen_A", 32'(A), 32'hC0001);
    chk("reopen_over", 32'(game_over), 32'd0);
    send(2'b00, 4'd9, 4'd0, 2'b00, 1, 2, 1'b0);
    chk("placeJ", 32'(J), 32'h40000);
    chk("placeJ_cells", 32'(ship_cells), 32'd2);
    send(2'b10, 4'd0, 4'd0, 2'b00, 11, 12, 1'b1);
    for (int r = 0; r < 10; r++) exp_rows[r] = 20'd0;
    check_rows("after_clear");
    chk("clr_cells", 32'(ship_cells), 32'd0);
    chk("clr_over", 32'(game_over), 32'd0);
    chk("clr_turn", 32'(playerTurn), 32'd0);

    // Miss on water, then repeat fire.
    send(2'b01, 4'd9, 4'd9, 2'b00, 1, 2, 1'b0);
    chk("miss_J", 32'(J), 32'h00002);
    chk("miss_turn", 32'(playerTurn), 32'd1);
    send(2'b01, 4'd9, 4'd9, 2'b10, 1, 2, 1'b0);
    chk("refire_turn", 32'(playerTurn), 32'd1);

    // Out-of-range and reserved opcode.
    send(2'b00, 4'd10, 4'd3, 2'b11, 1, 2, 1'b0);
    send(2'b01, 4'd2, 4'd12, 2'b11, 1, 2, 1'b0);
    send(2'b11, 4'd1, 4'd1, 2'b11, 1, 2, 1'b0);
    exp_rows[9] = 20'h00002;
    check_rows("oor");
    chk("oor_cells", 32'(ship_cells), 32'd0);
    chk("oor_turn", 32'(playerTurn), 32'd1);

    // A hit that leaves ships afloat does not end the game.
    send(2'b00, 4'd4, 4'd4, 2'b00, 1, 2, 1'b0);
    send(2'b00, 4'd4, 4'd5, 2'b00, 1, 2, 1'b0);
    chk("two_E", 32'(E), 32'h00500);
    send(2'b01, 4'd4, 4'd4, 2'b01, 1, 2, 1'b0);
    chk("hitE", 32'(E), 32'h00D00);
    chk("hitE_cells", 32'(ship_cells), 32'd1);
    chk("hitE_over", 32'(game_over), 32'd0);
    chk("hitE_turn", 32'(playerTurn), 32'd0);

    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clock50);
    end
    repeat (3) @(negedge clock50);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
